// File: rtl/timer_pkg.sv
// Shared types and constants for the microwave timer digit receiver:
// debounce FSM states, the encoder's no-key code and active-low
// 7-segment patterns ordered {g,f,e,d,c,b,a}.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } rx_state_t;

    localparam logic [3:0] NO_KEY = 4'hF;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment pattern {g,f,e,d,c,b,a}.
// Codes above 9 never reach this decoder; they show blank for safety.
module bcd_to_7seg
    import timer_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    // Pattern lookup for one digit.
    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/timer_digit_receiver.sv
// Keypad encoder receiver for the microwave timer: synchronizes and
// debounces the encoder digit, shifts accepted digits into a BCD MM:SS
// entry register and scans it onto a multiplexed active-low display.
// Optional build macro TIMER_RX_BLANK_EN enables leading-zero blanking.
//
// Handshake: the encoder is level based (dv=0 with code 0..9 means a key is
// down); this block emits digit_strobe for exactly one cycle per accepted
// press, on the same edge that digits changes. dbg_state mirrors the FSM.
module timer_digit_receiver
    import timer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SCAN_DIV        = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  code,
    input  logic        dv,
    input  logic        load_en,
    input  logic        clear,
    output logic [15:0] digits,
    output logic        digit_strobe,
    output logic        time_valid,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic [1:0]  dbg_state
);

    localparam logic [7:0] DB_LAST   = 8'(DEBOUNCE_CYCLES);
    localparam bit         DB_ONE    = (DEBOUNCE_CYCLES == 1);
    localparam int         SCAN_CW   = $clog2(SCAN_DIV);
    localparam logic [SCAN_CW-1:0] SCAN_LAST = SCAN_CW'(SCAN_DIV - 1);

    logic [3:0]         r_code_s1, r_code_s2;
    logic               r_dv_s1, r_dv_s2;
    rx_state_t          r_state;
    logic [7:0]         r_cnt;
    logic [3:0]         r_ref;
    logic [15:0]        r_digits;
    logic               r_strobe;
    logic [SCAN_CW-1:0] r_scan_cnt;
    logic [1:0]         r_slot;
    logic [6:0]         r_seg;
    logic [3:0]         r_an;

    logic               w_key_valid;
    logic               w_same_key;
    logic [7:0]         w_cnt_inc;
    logic               w_accept;
    logic [3:0]         w_acc_digit;
    logic [3:0]         w_sel_digit;
    logic [6:0]         w_seg_raw;
    logic               w_blank;

    // Two-flop synchronizer; resets to the no-key condition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_code_s1 <= NO_KEY;
            r_code_s2 <= NO_KEY;
            r_dv_s1   <= 1'b1;
            r_dv_s2   <= 1'b1;
        end else begin
            r_code_s1 <= code;
            r_code_s2 <= r_code_s1;
            r_dv_s1   <= dv;
            r_dv_s2   <= r_dv_s1;
        end
    end

    // Key qualification and the accept decision shared by FSM and datapath.
    always_comb begin
        w_key_valid = !r_dv_s2 && (r_code_s2 <= 4'd9);
        w_same_key  = w_key_valid && (r_code_s2 == r_ref);
        w_cnt_inc   = r_cnt + 8'd1;
        w_accept    = 1'b0;
        w_acc_digit = r_ref;
        case (r_state)
            IDLE: begin
                // With a one-cycle debounce the first valid cycle already accepts.
                w_accept    = DB_ONE && w_key_valid;
                w_acc_digit = r_code_s2;
            end
            DEBOUNCE: w_accept = w_same_key && (w_cnt_inc >= DB_LAST);
            default:  w_accept = 1'b0;
        endcase
    end

    // Debounce FSM: press debounce, hold (no auto-repeat), release debounce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
            r_ref   <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_key_valid) begin
                        r_ref   <= r_code_s2;
                        r_cnt   <= 8'd1;
                        r_state <= DB_ONE ? HELD : DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (w_same_key) begin
                        if (w_cnt_inc >= DB_LAST) r_state <= HELD;
                        else                      r_cnt   <= w_cnt_inc;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                HELD: begin
                    if (!w_key_valid) begin
                        r_cnt   <= 8'd1;
                        r_state <= DB_ONE ? IDLE : RELEASE;
                    end
                end
                RELEASE: begin
                    if (w_key_valid) begin
                        r_state <= HELD;
                    end else if (w_cnt_inc >= DB_LAST) begin
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Entry register and strobe; clear overrides a coincident accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits <= 16'd0;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (clear) begin
                r_digits <= 16'd0;
            end else if (w_accept && load_en) begin
                r_digits <= {r_digits[11:0], w_acc_digit};
                r_strobe <= 1'b1;
            end
        end
    end

    // Scan timebase: slot advances once every SCAN_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt <= '0;
            r_slot     <= 2'd0;
        end else if (r_scan_cnt == SCAN_LAST) begin
            r_scan_cnt <= '0;
            r_slot     <= r_slot + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    // Digit selection and optional leading-zero blanking for the current slot.
    always_comb begin
        w_sel_digit = r_digits[r_slot*4 +: 4];
        w_blank     = 1'b0;
`ifdef TIMER_RX_BLANK_EN
        case (r_slot)
            2'd3:    w_blank = (r_digits[15:12] == 4'd0);
            2'd2:    w_blank = (r_digits[15:8]  == 8'd0);
            2'd1:    w_blank = (r_digits[15:4]  == 12'd0);
            default: w_blank = 1'b0;
        endcase
`else
        w_blank = 1'b0;
`endif
    end

    bcd_to_7seg u_dec (
        .i_bcd (w_sel_digit),
        .o_seg (w_seg_raw)
    );

    // Registered display drive so seg and an switch on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= 4'b1110;
            r_seg <= SEG_0;
        end else begin
            r_an  <= ~(4'b0001 << r_slot);
            r_seg <= w_blank ? SEG_BLANK : w_seg_raw;
        end
    end

    assign digits       = r_digits;
    assign digit_strobe = r_strobe;
    assign time_valid   = (r_digits[7:4] <= 4'd5);
    assign seg          = r_seg;
    assign an           = r_an;
    assign dbg_state    = r_state;

endmodule
